// File: rtl/buzzer_scheduler.sv
// rtl/buzzer_scheduler.sv - round-robin sound-effect scheduler driving buzzer enable and one-hot select
module buzzer_scheduler #(
  parameter int PLAY_CYCLES = 33_333_333,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  input  logic       cancel,
  output logic       buzz_en,
  output logic [5:0] se,
  output logic       busy,
  output logic [2:0] grant_id,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [31:0] PLAY_LOAD = 32'(PLAY_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [5:0]  pending, pending_n;
  logic [5:0]  se_n;
  logic [2:0]  last_grant, last_grant_n;
  logic [2:0]  grant_id_n;
  logic        done_n, aborted_n;
  logic [2:0]  winner, idx;
  logic        found;

  // Walk the six slots starting just after the last winner, wrapping at 5.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    idx    = (last_grant == 3'd5) ? 3'd0 : last_grant + 3'd1;
    for (int i = 0; i < 6; i++) begin
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pending_n    = pending | req;
    se_n         = se;
    grant_id_n   = grant_id;
    last_grant_n = last_grant;
    done_n       = 1'b0;
    aborted_n    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = PLAY;
          cnt_n        = PLAY_LOAD;
          se_n         = 6'b000001 << winner;
          grant_id_n   = winner;
          last_grant_n = winner;
          // A request on the grant edge re-sets the bit it would clear.
          pending_n    = (pending & ~(6'b000001 << winner)) | req;
        end
      end
      PLAY: begin
        if (cancel) begin
          state_n   = GAP;
          cnt_n     = GAP_LOAD;
          se_n      = 6'b0;
          aborted_n = 1'b1;
        end else if (cnt == 32'd0) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
          se_n    = 6'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      GAP: begin
        if (cnt == 32'd0) begin
          state_n = IDLE;
          cnt_n   = 32'd0;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 32'd0;
        se_n    = 6'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      pending    <= 6'b0;
      se         <= 6'b0;
      grant_id   <= 3'd0;
      last_grant <= 3'd5;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pending    <= pending_n;
      se         <= se_n;
      grant_id   <= grant_id_n;
      last_grant <= last_grant_n;
      done       <= done_n;
      aborted    <= aborted_n;
    end
  end

  assign buzz_en = (state == PLAY);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb/tb_buzzer_scheduler.sv - directed scenarios plus random traffic against a timestamp-based model
module tb_buzzer_scheduler;

  localparam int PLAY = 8;
  localparam int GAPC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] req = 6'b0;
  logic       cancel = 1'b0;
  logic       buzz_en, busy, done, aborted;
  logic [5:0] se;
  logic [2:0] grant_id;

  buzzer_scheduler #(.PLAY_CYCLES(PLAY), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst(rst), .req(req), .cancel(cancel),
    .buzz_en(buzz_en), .se(se), .busy(busy),
    .grant_id(grant_id), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: mode 0 idle, 1 playing, 2 silent gap; phases end by absolute edge number.
  int       m_mode = 0;
  logic [5:0] m_pend = 6'b0;
  int       m_last = 5;
  logic [5:0] m_se = 6'b0;
  int       m_gid = 0;
  logic     m_done = 1'b0, m_abort = 1'b0;
  int       m_t0 = 0;
  int       cyc = 0;

  int play_cnt, done_cnt, abort_cnt, busy_cnt, busy_rises, g_n;
  int g_list[8];
  logic prev_buzz = 1'b0, prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic [5:0] q, input logic c);
    logic found;
    int   idx;
    cyc++;
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (r) begin
      m_mode = 0; m_pend = 6'b0; m_last = 5; m_se = 6'b0; m_gid = 0;
      return;
    end
    case (m_mode)
      0: if (m_pend != 6'b0) begin
        found = 1'b0;
        for (int k = 1; k <= 6; k++) begin
          idx = (m_last + k) % 6;
          if (!found && m_pend[idx]) begin
            found = 1'b1;
            m_last = idx; m_gid = idx;
            m_se = 6'b0; m_se[idx] = 1'b1;
            m_pend[idx] = 1'b0;
          end
        end
        m_mode = 1; m_t0 = cyc;
      end
      1: if (c) begin
        m_mode = 2; m_t0 = cyc; m_abort = 1'b1;
      end else if (cyc - m_t0 == PLAY) begin
        m_mode = 2; m_t0 = cyc; m_done = 1'b1;
      end
      default: if (cyc - m_t0 == GAPC) m_mode = 0;
    endcase
    m_pend = m_pend | q;
  endtask

  task automatic clr_stats();
    play_cnt = 0; done_cnt = 0; abort_cnt = 0; busy_cnt = 0; busy_rises = 0; g_n = 0;
  endtask

  task automatic tick(input logic r, input logic [5:0] q, input logic c);
    rst = r; req = q; cancel = c;
    model_step(r, q, c);
    @(posedge clk);
    #1;
    chk("buzz_en", 32'(buzz_en), 32'(m_mode == 1));
    chk("se", 32'(se), (m_mode == 1) ? 32'(m_se) : 32'd0);
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("done", 32'(done), 32'(m_done));
    chk("aborted", 32'(aborted), 32'(m_abort));
    if (buzz_en) play_cnt++;
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
    if (busy) busy_cnt++;
    if (busy && !prev_busy) busy_rises++;
    if (buzz_en && !prev_buzz && g_n < 8) begin
      g_list[g_n] = int'(grant_id);
      g_n++;
    end
    prev_buzz = buzz_en;
    prev_busy = busy;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 6'b0, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b1, 6'b0, 1'b0);
    tick(1'b1, 6'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("reset_buzz", 32'(buzz_en), 32'd0);
    chk("reset_se", 32'(se), 32'd0);
    chk("reset_gid", 32'(grant_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Single request: effect 2 after one edge, 8 play, 2 gap, one done.
    clr_stats();
    tick(1'b0, 6'b000100, 1'b0);
    chk("single_not_yet", 32'(buzz_en), 32'd0);
    tick(1'b0, 6'b0, 1'b0);
    chk("single_buzz", 32'(buzz_en), 32'd1);
    chk("single_se", 32'(se), 32'h04);
    chk("single_gid", 32'(grant_id), 32'd2);
    idle_run(20);
    chk("single_play_len", 32'(play_cnt), 32'd8);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);
    chk("single_busy_len", 32'(busy_cnt), 32'd10);
    chk("single_end_busy", 32'(busy), 32'd0);

    // Round robin from reset: 0 then 5, two separate busy windows.
    do_reset();
    clr_stats();
    tick(1'b0, 6'b100001, 1'b0);
    idle_run(40);
    chk("rr_grants", 32'(g_n), 32'd2);
    chk("rr_first", 32'(g_list[0]), 32'd0);
    chk("rr_second", 32'(g_list[1]), 32'd5);
    chk("rr_busy_len", 32'(busy_cnt), 32'd20);
    chk("rr_busy_windows", 32'(busy_rises), 32'd2);

    // Fairness: after 3, pending {1,4} serves 4 first.
    do_reset();
    clr_stats();
    tick(1'b0, 6'b001000, 1'b0);
    tick(1'b0, 6'b0, 1'b0);
    tick(1'b0, 6'b010010, 1'b0);
    idle_run(40);
    chk("fair_grants", 32'(g_n), 32'd3);
    chk("fair_first", 32'(g_list[0]), 32'd3);
    chk("fair_second", 32'(g_list[1]), 32'd4);
    chk("fair_third", 32'(g_list[2]), 32'd1);

    // Cancel during the third play cycle.
    do_reset();
    clr_stats();
    tick(1'b0, 6'b000001, 1'b0);
    tick(1'b0, 6'b0, 1'b0);
    tick(1'b0, 6'b0, 1'b0);
    tick(1'b0, 6'b0, 1'b0);
    chk("cancel_pre_buzz", 32'(buzz_en), 32'd1);
    tick(1'b0, 6'b0, 1'b1);
    chk("cancel_buzz", 32'(buzz_en), 32'd0);
    chk("cancel_aborted", 32'(aborted), 32'd1);
    chk("cancel_done", 32'(done), 32'd0);
    tick(1'b0, 6'b0, 1'b1);
    chk("cancel_gap2_busy", 32'(busy), 32'd1);
    chk("cancel_pulse_once", 32'(aborted), 32'd0);
    tick(1'b0, 6'b0, 1'b0);
    chk("cancel_gap_end", 32'(busy), 32'd0);
    chk("cancel_done_total", 32'(done_cnt), 32'd0);

    // Replay of the effect currently playing.
    do_reset();
    clr_stats();
    tick(1'b0, 6'b000100, 1'b0);
    tick(1'b0, 6'b0, 1'b0);
    tick(1'b0, 6'b000100, 1'b0);
    idle_run(40);
    chk("replay_grants", 32'(g_n), 32'd2);
    chk("replay_id", 32'(g_list[1]), 32'd2);
    chk("replay_windows", 32'(busy_rises), 32'd2);

    // Reset mid-play with another effect pending.
    do_reset();
    tick(1'b0, 6'b000001, 1'b0);
    tick(1'b0, 6'b0, 1'b0);
    tick(1'b0, 6'b000010, 1'b0);
    tick(1'b1, 6'b0, 1'b0);
    chk("rstmid_buzz", 32'(buzz_en), 32'd0);
    chk("rstmid_se", 32'(se), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_gid", 32'(grant_id), 32'd0);
    clr_stats();
    idle_run(40);
    chk("rstmid_no_play", 32'(play_cnt), 32'd0);

    // Requests sampled with reset are dropped.
    tick(1'b1, 6'b111111, 1'b1);
    clr_stats();
    idle_run(5);
    chk("rst_drops_req", 32'(busy_cnt), 32'd0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] q;
      q = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'b0;
      tick(($urandom_range(0, 599) == 0), q, ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
